// File: rtl/mem_request_queue.sv
`timescale 1ns/1ps
// In-order load/store request queue that sits in front of data_memory_system.
// Optional statistics counters are enabled with `define MEMQ_STATS_EN.
module mem_request_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [DATA_WIDTH-1:0] ReqData,
  output logic                  RspValid,
  output logic [DATA_WIDTH-1:0] RspData,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] WordAddress,
  output logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  Stall,
  input  logic [DATA_WIDTH-1:0] DataOut,
  output logic                  Empty
`ifdef MEMQ_STATS_EN
  ,
  output logic [15:0]           StallCycles,
  output logic [15:0]           ReqCount
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, ACTIVE} stateT;

  stateT             stateReg;
  logic [PTR_W-1:0]  wrPtrReg;
  logic [PTR_W-1:0]  rdPtrReg;
  logic [PTR_W:0]    countReg;

  logic                  writeMem [DEPTH];
  logic [ADDR_WIDTH-1:0] addrMem  [DEPTH];
  logic [DATA_WIDTH-1:0] dataMem  [DEPTH];

  logic                  headWrite;
  logic [ADDR_WIDTH-1:0] headAddr;
  logic [DATA_WIDTH-1:0] headData;
  logic                  push;
  logic                  pop;
  logic                  fifoNonEmpty;

  assign fifoNonEmpty = (countReg != '0);
  assign ReqReady     = (countReg != FullCount);
  assign Empty        = !fifoNonEmpty && (stateReg == IDLE);
  assign push         = ReqValid && ReqReady;
  // The head is consumed whenever the mem port is free or freeing up this edge.
  assign pop          = fifoNonEmpty && ((stateReg == IDLE) || !Stall);

  assign headWrite = writeMem[rdPtrReg];
  assign headAddr  = addrMem[rdPtrReg];
  assign headData  = dataMem[rdPtrReg];

  // Storage carries no reset so it can map onto distributed or block RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      writeMem[wrPtrReg] <= ReqWrite;
      addrMem[wrPtrReg]  <= ReqAddr;
      dataMem[wrPtrReg]  <= ReqData;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      stateReg    <= IDLE;
      wrPtrReg    <= '0;
      rdPtrReg    <= '0;
      countReg    <= '0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      WordAddress <= '0;
      DataIn      <= '0;
      RspValid    <= 1'b0;
      RspData     <= '0;
    end else begin
      RspValid <= 1'b0;

      if (push) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (pop)  rdPtrReg <= rdPtrReg + PTR_W'(1);

      if (push && !pop)
        countReg <= countReg + (PTR_W + 1)'(1);
      else if (!push && pop)
        countReg <= countReg - (PTR_W + 1)'(1);

      case (stateReg)
        IDLE: begin
          if (fifoNonEmpty) begin
            WordAddress <= headAddr;
            DataIn      <= headData;
            MemRead     <= !headWrite;
            MemWrite    <= headWrite;
            stateReg    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!Stall) begin
            if (MemRead) begin
              RspData  <= DataOut;
              RspValid <= 1'b1;
            end
            // Chain straight into the next request so there is no idle bubble.
            if (fifoNonEmpty) begin
              WordAddress <= headAddr;
              DataIn      <= headData;
              MemRead     <= !headWrite;
              MemWrite    <= headWrite;
            end else begin
              MemRead  <= 1'b0;
              MemWrite <= 1'b0;
              stateReg <= IDLE;
            end
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

`ifdef MEMQ_STATS_EN
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      StallCycles <= '0;
      ReqCount    <= '0;
    end else if (stateReg == ACTIVE) begin
      if (Stall && (StallCycles != 16'hFFFF))
        StallCycles <= StallCycles + 16'd1;
      if (!Stall && (ReqCount != 16'hFFFF))
        ReqCount <= ReqCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_request_queue.sv
`timescale 1ns/1ps
// Directed bench for mem_request_queue: a cycle-by-cycle vector table plus
// hand-written reset-while-busy and statistics sequences.
module tb_mem_request_queue;

  logic        CLK = 1'b0;
  logic        rst;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [9:0]  ReqAddr;
  logic [31:0] ReqData;
  logic        RspValid;
  logic [31:0] RspData;
  logic        MemRead;
  logic        MemWrite;
  logic [9:0]  WordAddress;
  logic [31:0] DataIn;
  logic        Stall;
  logic [31:0] DataOut;
  logic        Empty;
`ifdef MEMQ_STATS_EN
  logic [15:0] StallCycles;
  logic [15:0] ReqCount;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 CLK = ~CLK;

  mem_request_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(4)) dut (
    .CLK(CLK), .rst(rst),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqData(ReqData),
    .RspValid(RspValid), .RspData(RspData),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .WordAddress(WordAddress), .DataIn(DataIn),
    .Stall(Stall), .DataOut(DataOut), .Empty(Empty)
`ifdef MEMQ_STATS_EN
    , .StallCycles(StallCycles), .ReqCount(ReqCount)
`endif
  );

  typedef struct {
    logic        v;
    logic        w;
    logic [9:0]  a;
    logic [31:0] d;
    logic        s;
    logic [31:0] dout;
    logic        rdy;
    logic        mr;
    logic        mw;
    logic [9:0]  wa;
    logic [31:0] di;
    logic        rv;
    logic [31:0] rd;
    logic        e;
  } vecT;

  vecT vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [9:0] a,
                       input logic [31:0] d, input logic s, input logic [31:0] dout);
    ReqValid = v; ReqWrite = w; ReqAddr = a; ReqData = d; Stall = s; DataOut = dout;
  endtask

  task automatic checkIdleReset(input string tag);
    check({tag, ".MemRead"},     {31'd0, MemRead},  32'd0);
    check({tag, ".MemWrite"},    {31'd0, MemWrite}, 32'd0);
    check({tag, ".WordAddress"}, {22'd0, WordAddress}, 32'd0);
    check({tag, ".DataIn"},      DataIn,  32'd0);
    check({tag, ".RspValid"},    {31'd0, RspValid}, 32'd0);
    check({tag, ".RspData"},     RspData, 32'd0);
    check({tag, ".ReqReady"},    {31'd0, ReqReady}, 32'd1);
    check({tag, ".Empty"},       {31'd0, Empty},    32'd1);
  endtask

  initial begin
    // columns: v w addr data stall dout | rdy mr mw wa di rv rd empty
    // load @003, no stall
    vecs.push_back(vecT'{1'b1,1'b0,10'h003,32'h0,1'b0,32'hDEADBEEF, 1'b1,1'b0,1'b0,10'h000,32'h0,1'b0,32'h0,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b0,32'hDEADBEEF, 1'b1,1'b1,1'b0,10'h003,32'h0,1'b0,32'h0,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b0,32'hDEADBEEF, 1'b1,1'b0,1'b0,10'h003,32'h0,1'b1,32'hDEADBEEF,1'b1});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b0,32'hDEADBEEF, 1'b1,1'b0,1'b0,10'h003,32'h0,1'b0,32'hDEADBEEF,1'b1});
    // store @010 with three stall edges
    vecs.push_back(vecT'{1'b1,1'b1,10'h010,32'h12345678,1'b0,32'hBAD0BAD0, 1'b1,1'b0,1'b0,10'h003,32'h0,1'b0,32'hDEADBEEF,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b1,32'hBAD0BAD0, 1'b1,1'b0,1'b1,10'h010,32'h12345678,1'b0,32'hDEADBEEF,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b1,32'hBAD0BAD0, 1'b1,1'b0,1'b1,10'h010,32'h12345678,1'b0,32'hDEADBEEF,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b1,32'hBAD0BAD0, 1'b1,1'b0,1'b1,10'h010,32'h12345678,1'b0,32'hDEADBEEF,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b1,32'hBAD0BAD0, 1'b1,1'b0,1'b1,10'h010,32'h12345678,1'b0,32'hDEADBEEF,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b0,32'hBAD0BAD0, 1'b1,1'b0,1'b0,10'h010,32'h12345678,1'b0,32'hDEADBEEF,1'b1});
    // five pushes under stall, sixth rejected, then drain back-to-back
    vecs.push_back(vecT'{1'b1,1'b0,10'h020,32'h0,1'b1,32'h0, 1'b1,1'b0,1'b0,10'h010,32'h12345678,1'b0,32'hDEADBEEF,1'b0});
    vecs.push_back(vecT'{1'b1,1'b1,10'h021,32'h1111,1'b1,32'h0, 1'b1,1'b1,1'b0,10'h020,32'h0,1'b0,32'hDEADBEEF,1'b0});
    vecs.push_back(vecT'{1'b1,1'b0,10'h022,32'h0,1'b1,32'h0, 1'b1,1'b1,1'b0,10'h020,32'h0,1'b0,32'hDEADBEEF,1'b0});
    vecs.push_back(vecT'{1'b1,1'b0,10'h023,32'h0,1'b1,32'h0, 1'b1,1'b1,1'b0,10'h020,32'h0,1'b0,32'hDEADBEEF,1'b0});
    vecs.push_back(vecT'{1'b1,1'b1,10'h024,32'h2222,1'b1,32'h0, 1'b0,1'b1,1'b0,10'h020,32'h0,1'b0,32'hDEADBEEF,1'b0});
    vecs.push_back(vecT'{1'b1,1'b0,10'h025,32'h0,1'b1,32'h0, 1'b0,1'b1,1'b0,10'h020,32'h0,1'b0,32'hDEADBEEF,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b0,32'hA0A0A0A0, 1'b1,1'b0,1'b1,10'h021,32'h1111,1'b1,32'hA0A0A0A0,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b0,32'hB1B1B1B1, 1'b1,1'b1,1'b0,10'h022,32'h0,1'b0,32'hA0A0A0A0,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b0,32'hC2C2C2C2, 1'b1,1'b1,1'b0,10'h023,32'h0,1'b1,32'hC2C2C2C2,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b0,32'hD3D3D3D3, 1'b1,1'b0,1'b1,10'h024,32'h2222,1'b1,32'hD3D3D3D3,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b0,32'hE4E4E4E4, 1'b1,1'b0,1'b0,10'h024,32'h2222,1'b0,32'hD3D3D3D3,1'b1});
    // store 00A=55 then load 00A: no forwarding, strict order
    vecs.push_back(vecT'{1'b1,1'b1,10'h00A,32'h55,1'b0,32'h0, 1'b1,1'b0,1'b0,10'h024,32'h2222,1'b0,32'hD3D3D3D3,1'b0});
    vecs.push_back(vecT'{1'b1,1'b0,10'h00A,32'h0,1'b0,32'h0, 1'b1,1'b0,1'b1,10'h00A,32'h55,1'b0,32'hD3D3D3D3,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b0,32'h55, 1'b1,1'b1,1'b0,10'h00A,32'h0,1'b0,32'hD3D3D3D3,1'b0});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b0,32'h55, 1'b1,1'b0,1'b0,10'h00A,32'h0,1'b1,32'h55,1'b1});
    vecs.push_back(vecT'{1'b0,1'b0,10'h000,32'h0,1'b0,32'h0, 1'b1,1'b0,1'b0,10'h00A,32'h0,1'b0,32'h55,1'b1});

    rst = 1'b1;
    drive(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    checkIdleReset("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].dout);
      tick();
      $display("vec %0d: v=%0b w=%0b a=%03h stall=%0b -> rdy=%0b rd=%0b wr=%0b wa=%03h di=%08h rv=%0b rsp=%08h empty=%0b",
               i, vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].s,
               ReqReady, MemRead, MemWrite, WordAddress, DataIn, RspValid, RspData, Empty);
      check($sformatf("v%0d.ReqReady", i),    {31'd0, ReqReady},    {31'd0, vecs[i].rdy});
      check($sformatf("v%0d.MemRead", i),     {31'd0, MemRead},     {31'd0, vecs[i].mr});
      check($sformatf("v%0d.MemWrite", i),    {31'd0, MemWrite},    {31'd0, vecs[i].mw});
      check($sformatf("v%0d.WordAddress", i), {22'd0, WordAddress}, {22'd0, vecs[i].wa});
      check($sformatf("v%0d.DataIn", i),      DataIn,               vecs[i].di);
      check($sformatf("v%0d.RspValid", i),    {31'd0, RspValid},    {31'd0, vecs[i].rv});
      check($sformatf("v%0d.RspData", i),     RspData,              vecs[i].rd);
      check($sformatf("v%0d.Empty", i),       {31'd0, Empty},       {31'd0, vecs[i].e});
    end

    // Reset while ACTIVE with three requests queued.
    drive(1'b1, 1'b0, 10'h030, 32'h0, 1'b1, 32'h0);        tick();
    drive(1'b1, 1'b1, 10'h031, 32'h77, 1'b1, 32'h0);       tick();
    drive(1'b1, 1'b0, 10'h032, 32'h0, 1'b1, 32'h0);        tick();
    drive(1'b1, 1'b0, 10'h033, 32'h0, 1'b1, 32'h0);        tick();
    $display("busy before reset: rd=%0b wa=%03h empty=%0b", MemRead, WordAddress, Empty);
    check("busy.MemRead",     {31'd0, MemRead},     32'd1);
    check("busy.WordAddress", {22'd0, WordAddress}, 32'h030);
    check("busy.Empty",       {31'd0, Empty},       32'd0);
    ReqValid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: rd=%0b wr=%0b rdy=%0b empty=%0b", MemRead, MemWrite, ReqReady, Empty);
    checkIdleReset("asyncrst");
    #2;
    rst = 1'b0;
    drive(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 32'hFFFFFFFF);
    for (int c = 0; c < 6; c++) begin
      tick();
      $display("post-reset cycle %0d: rv=%0b rd=%0b wr=%0b", c, RspValid, MemRead, MemWrite);
      check($sformatf("postrst%0d.RspValid", c), {31'd0, RspValid}, 32'd0);
      check($sformatf("postrst%0d.MemAccess", c), {30'd0, MemRead, MemWrite}, 32'd0);
    end

`ifdef MEMQ_STATS_EN
    check("stats.initStall", {16'd0, StallCycles}, 32'd0);
    check("stats.initReq",   {16'd0, ReqCount},    32'd0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 10'h040 + 10'(k), 32'h0, 1'b1, 32'h0); tick();
      drive(1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 32'h0);          tick();
      tick();
      tick();
      drive(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 32'h99);         tick();
      $display("stats load %0d: stallCycles=%0d reqCount=%0d", k, StallCycles, ReqCount);
    end
    Stall = 1'b1;
    tick();
    tick();
    check("stats.StallCycles", {16'd0, StallCycles}, 32'd4);
    check("stats.ReqCount",    {16'd0, ReqCount},    32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
